// File: rtl/rdcla_pkg.sv
// Shared definitions for the recursive-doubling carry-lookahead adder.
// Holds the default datapath width, the matching prefix depth and the
// generate/propagate pair that flows through the prefix network.
package rdcla_pkg;

    localparam int RDCLA_WIDTH  = 64;
    localparam int RDCLA_LEVELS = 6;

    // Group generate / group propagate pair carried through the prefix tree
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/rdcla_gp_cell.sv
// Prefix combine operator for the carry-lookahead network.
// Merges a higher-order group (hi) with the adjacent lower-order group (lo):
// the merged group generates if hi generates, or hi propagates a carry
// generated by lo; it propagates only if both halves propagate.
module rdcla_gp_cell
    import rdcla_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t gp
);

    assign gp.g = hi.g | (hi.p & lo.g);
    assign gp.p = hi.p & lo.p;

endmodule

// File: rtl/rdcla_adder64.sv
// Registered WIDTH-bit adder with carry-in and carry-out built on a
// Kogge-Stone style parallel-prefix carry network (log2(WIDTH) levels).
// One result per clock; the only state is the output register, so there
// is no combinational path from the operand inputs to the outputs.
module rdcla_adder64
    import rdcla_pkg::*;
#(
    parameter int WIDTH = RDCLA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    // Prefix depth follows the width; it is not meant to be overridden.
    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_nxt;

    // lvl[k][i] is the (G,P) pair of bit i entering prefix level k.
    // The final level is evaluated inline below because only its
    // generate term (the carry) is consumed.
    gp_t lvl [LEVELS][WIDTH];

    // ---- bit-level generate / propagate ----
    assign g = in1 & in2;
    assign p = in1 ^ in2;

    // Carry-in acts as a generate at position -1. Folding it into bit 0
    // up front means every group that reaches bit 0 already includes cin,
    // so a pass-through node's G is the finished carry into the next bit.
    genvar i, k;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lvl0
            if (i == 0) begin : g_bit0
                assign lvl[0][0] = '{g: g[0] | (p[0] & cin), p: p[0]};
            end else begin : g_bitn
                assign lvl[0][i] = '{g: g[i], p: p[i]};
            end
        end

        // ---- prefix levels 0 .. LEVELS-2: span doubles every level ----
        for (k = 0; k < LEVELS - 1; k++) begin : g_level
            localparam int D = 1 << k;
            for (i = 0; i < WIDTH; i++) begin : g_node
                if (i >= D) begin : g_comb
                    rdcla_gp_cell u_cell (
                        .hi (lvl[k][i]),
                        .lo (lvl[k][i-D]),
                        .gp (lvl[k+1][i])
                    );
                end else begin : g_pass
                    assign lvl[k+1][i] = lvl[k][i];
                end
            end
        end

        // ---- last prefix level: only the group generate (carry) is needed ----
        for (i = 0; i < WIDTH; i++) begin : g_carry
            localparam int DL = 1 << (LEVELS - 1);
            if (i >= DL) begin : g_comb
                assign c[i+1] = lvl[LEVELS-1][i].g
                              | (lvl[LEVELS-1][i].p & lvl[LEVELS-1][i-DL].g);
            end else begin : g_pass
                assign c[i+1] = lvl[LEVELS-1][i].g;
            end
        end
    endgenerate

    // ---- sum formation ----
    assign c[0]    = cin;
    assign sum_nxt = p ^ c[WIDTH-1:0];

    // Output register: capture on valid, hold data otherwise; valid follows input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_nxt;
                cout <= c[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_rdcla_adder64.sv
// Self-checking bench for rdcla_adder64: directed vectors with fixed
// expected values plus randomized traffic against a 65-bit arithmetic model.
module tb_rdcla_adder64;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the outputs must show after the last edge
    logic [63:0] exp_sum;
    logic        exp_cout;
    logic        exp_vld;

    rdcla_adder64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_sum"},  {1'b0, sum},   {1'b0, exp_sum});
        check_val({tag, "_cout"}, {64'd0, cout}, {64'd0, exp_cout});
        check_val({tag, "_vld"},  {64'd0, out_valid}, {64'd0, exp_vld});
    endtask

    // Called at a falling edge: drive operands, make sure nothing leaks
    // through before the clock, update the model at the rising edge and
    // compare at the next falling edge.
    task automatic run_cycle(input logic [63:0] a, input logic [63:0] b,
                             input logic ci, input logic v, input string tag);
        logic [64:0] full;
        in1      = a;
        in2      = b;
        cin      = ci;
        in_valid = v;
        #1;
        check_val({tag, "_pre"}, {cout, sum}, {exp_cout, exp_sum});
        @(posedge clk);
        if (!rst_n) begin
            exp_sum  = '0;
            exp_cout = 1'b0;
            exp_vld  = 1'b0;
        end else begin
            exp_vld = v;
            if (v) begin
                full     = {1'b0, a} + {1'b0, b} + {64'd0, ci};
                exp_sum  = full[63:0];
                exp_cout = full[64];
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Directed vector: model comparison plus a check against the fixed answer
    task automatic run_dir(input logic [63:0] a, input logic [63:0] b, input logic ci,
                           input logic [63:0] want_sum, input logic want_cout, input string tag);
        run_cycle(a, b, ci, 1'b1, tag);
        check_val({tag, "_fixed"}, {cout, sum}, {want_cout, want_sum});
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic        rc, rv;
        int          sel;

        rst_n    = 1'b1;
        in_valid = 1'b1;
        in1      = {$urandom, $urandom};
        in2      = {$urandom, $urandom};
        cin      = 1'b1;
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_vld  = 1'b0;

        // ---- asynchronous reset with live inputs ----
        #1 rst_n = 1'b0;
        #1 check_outputs("rst_async");
        @(negedge clk);
        run_cycle({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, "rst_hold");
        run_cycle({$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "rst_hold2");
        rst_n = 1'b1;
        run_cycle(64'd0, 64'd0, 1'b0, 1'b0, "rst_release");

        // ---- directed vectors, back to back ----
        run_dir(64'd4, 64'd3, 1'b0, 64'd7, 1'b0, "small");
        run_dir(64'd1, 64'd100000000101, 1'b0, 64'd100000000102, 1'b0, "dec");
        run_dir(64'h4D3785B7, 64'h253AF8CA3, 1'b0, 64'h2A0E7125A, 1'b0, "mix1");
        run_dir(64'h12AB47, 64'h3AAD8C1C, 1'b0, 64'h3AC03763, 1'b0, "mix2");
        run_dir(64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd2, 1'b1, "ripple3");
        run_dir(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, "ripple_cin");
        run_dir(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, "msb");
        run_dir(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "allones");

        // ---- hold: invalid cycles with changing and unknown operands ----
        run_cycle({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, "hold1");
        run_cycle(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, "hold2");
        run_cycle('x, 'x, 1'bx, 1'b0, "hold_x");
        check_val("hold_value", {cout, sum}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});

        // ---- reset asserted mid-stream ----
        run_cycle(64'd123456789, 64'd987654321, 1'b1, 1'b1, "pre_mid");
        in_valid = 1'b1;
        in1      = 64'd55;
        in2      = 64'd66;
        #2 rst_n = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_vld  = 1'b0;
        #1 check_outputs("mid_rst_async");
        @(negedge clk);
        run_cycle(64'd55, 64'd66, 1'b0, 1'b1, "mid_rst_hold");
        rst_n = 1'b1;
        run_cycle(64'd10, 64'd20, 1'b1, 1'b1, "post_rst");

        // ---- randomized traffic, biased toward long carry chains ----
        for (int n = 0; n < 10000; n++) begin
            sel = $urandom_range(0, 7);
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if (sel == 0) rb = ~ra;
            if (sel == 1) rb = ~ra + 64'({$urandom} % 4);
            if (sel == 2) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            if (sel == 3) ra = ra >> $urandom_range(0, 63);
            rc = 1'($urandom);
            rv = ($urandom_range(0, 9) != 0);
            run_cycle(ra, rb, rc, rv, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
